// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matmul control/result paths:
// default sizes, FSM state encoding and the row-major flat packing helper.
package systolic_pkg;

   localparam int W_DEF = 16;
   localparam int N_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // LSB of element (r,c) in an n x n matrix of w-bit elements, (0,0) at the MSB
   function automatic int elem_lsb(input int r, input int c, input int n, input int w);
      return w * (n*n - 1 - (r*n + c));
   endfunction

endpackage

// File: rtl/drain_lane.sv
// One column lane of the result drain: tracks how many rows this column has
// delivered, derives the destination row (bottom row emerges first) and flags
// completion and over-delivery.
module drain_lane #(
   parameter int N  = 3,
   parameter int KW = $clog2(N+1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,      // restart: forget all delivered rows
   input  logic          i_collect,  // beats are accepted this cycle
   input  logic          i_vld,
   output logic          o_we,
   output logic [KW-1:0] o_row,
   output logic          o_done,     // column complete after this cycle's update
   output logic          o_ovf
);

   logic [KW-1:0] r_k;
   logic          w_full;

   assign w_full = (r_k == KW'(N));
   assign o_we   = i_collect & i_vld & ~w_full;
   assign o_ovf  = i_collect & i_vld &  w_full;
   assign o_row  = KW'(N-1) - r_k;
   assign o_done = w_full | (o_we & (r_k == KW'(N-1)));

   // Per-lane beat counter; clear wins over a same-cycle beat
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)   r_k <= '0;
      else if (i_clr) r_k <= '0;
      else if (o_we)  r_k <= r_k + KW'(1);
   end

endmodule

// File: rtl/systolic_drain.sv
// Result drain for the N x N output-stationary systolic array: gathers the
// skewed per-column result stream into a row-major C matrix and presents it
// with a valid/ready handshake.
// Optional: define SYSTOLIC_DRAIN_TIMEOUT_EN to abort a COLLECT phase that
// lasts TIMEOUT cycles without completing.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int N       = N_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [N-1:0]     i_lane_vld,
   input  logic [W*N-1:0]   i_lane_data,
   output logic             o_lane_rdy,
   output logic [W*N*N-1:0] o_C,
   output logic             o_C_vld,
   input  logic             i_C_rdy,
   output logic             o_err,
   output logic             o_busy
);

   localparam int KW = $clog2(N+1);

   state_t             r_state;
   logic [W*N*N-1:0]   r_C;
   logic               r_C_vld;
   logic               r_lane_rdy;
   logic               r_err;
   logic               r_busy;

   logic               w_collect;
   logic               w_clr;
   logic [N-1:0]       w_we;
   logic [N-1:0]       w_done;
   logic [N-1:0]       w_ovf;
   logic [N-1:0][KW-1:0] w_row;

   // A start pulse in COLLECT is a restart, so beats that cycle are dropped
   assign w_collect = (r_state == ST_COLLECT) & ~i_start;
   assign w_clr     = i_start & ((r_state == ST_IDLE) | (r_state == ST_COLLECT));

   for (genvar j = 0; j < N; j++) begin : g_lane
      drain_lane #(.N(N), .KW(KW)) u_lane (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_clr     (w_clr),
         .i_collect (w_collect),
         .i_vld     (i_lane_vld[j]),
         .o_we      (w_we[j]),
         .o_row     (w_row[j]),
         .o_done    (w_done[j]),
         .o_ovf     (w_ovf[j])
      );
   end

`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0] r_tmr;
`endif

   // Control FSM, matrix bank and sticky error, all with registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_C        <= '0;
         r_C_vld    <= 1'b0;
         r_lane_rdy <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
         r_tmr      <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|i_lane_vld) r_err <= 1'b1;
               if (i_start) begin
                  r_state    <= ST_COLLECT;
                  r_C        <= '0;
                  r_lane_rdy <= 1'b1;
                  r_busy     <= 1'b1;
`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
                  r_tmr      <= '0;
`endif
               end
            end
            ST_COLLECT: begin
               if (i_start) begin
                  r_err <= 1'b1;
                  r_C   <= '0;
`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
                  r_tmr <= '0;
`endif
               end else begin
                  for (int j = 0; j < N; j++)
                     for (int r = 0; r < N; r++)
                        if (w_we[j] && (w_row[j] == KW'(r)))
                           r_C[elem_lsb(r, j, N, W) +: W] <= i_lane_data[W*j +: W];
                  if (|w_ovf) r_err <= 1'b1;
                  if (&w_done) begin
                     r_state    <= ST_HOLD;
                     r_C_vld    <= 1'b1;
                     r_lane_rdy <= 1'b0;
                  end
`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
                  // Partial matrix is left in place, never flagged valid
                  else if (r_tmr == TW'(TIMEOUT-1)) begin
                     r_state    <= ST_IDLE;
                     r_err      <= 1'b1;
                     r_lane_rdy <= 1'b0;
                     r_busy     <= 1'b0;
                  end else begin
                     r_tmr <= r_tmr + TW'(1);
                  end
`endif
               end
            end
            ST_HOLD: begin
               if (|i_lane_vld) r_err <= 1'b1;
               if (i_C_rdy) begin
                  r_state <= ST_IDLE;
                  r_C_vld <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_C_vld    <= 1'b0;
               r_lane_rdy <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign o_C        = r_C;
   assign o_C_vld    = r_C_vld;
   assign o_lane_rdy = r_lane_rdy;
   assign o_err      = r_err;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain (default build, N=3, W=16).
module tb_systolic_drain;

   localparam int W  = 16;
   localparam int N  = 3;
   localparam int CW = W*N*N;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_start;
   logic [N-1:0]    i_lane_vld;
   logic [W*N-1:0]  i_lane_data;
   logic            o_lane_rdy;
   logic [CW-1:0]   o_C;
   logic            o_C_vld;
   logic            i_C_rdy;
   logic            o_err;
   logic            o_busy;

   int n_chk = 0;
   int n_err = 0;
   logic [CW-1:0] sb[$];

   systolic_drain #(.W(W), .N(N), .TIMEOUT(64)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_lane_vld  (i_lane_vld),
      .i_lane_data (i_lane_data),
      .o_lane_rdy  (o_lane_rdy),
      .o_C         (o_C),
      .o_C_vld     (o_C_vld),
      .i_C_rdy     (i_C_rdy),
      .o_err       (o_err),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic beat(input logic [N-1:0] v, input logic [W*N-1:0] d);
      i_lane_vld  = v;
      i_lane_data = d;
      tick();
      i_lane_vld  = '0;
      i_lane_data = '0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Row-major packing model: (r,c) at W*(N*N-1-(r*N+c))
   function automatic logic [CW-1:0] pack_rc(input logic [W-1:0] m [N][N]);
      logic [CW-1:0] v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[W*(N*N-1-(r*N+c)) +: W] = m[r][c];
      return v;
   endfunction

   function automatic logic [CW-1:0] skew_mat();
      logic [W-1:0] m [N][N];
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = W'(16'h1000*r + c);
      return pack_rc(m);
   endfunction

   // Lane j's k-th beat carries row N-1-k: 0x1000*row + j
   function automatic logic [W*N-1:0] row_data(input int row);
      logic [W*N-1:0] d = '0;
      for (int j = 0; j < N; j++) d[W*j +: W] = W'(16'h1000*row + j);
      return d;
   endfunction

   task automatic wait_and_score(input string tag);
      logic [CW-1:0] exp;
      for (int i = 0; i < 50 && !o_C_vld; i++) tick();
      chk({tag, "_vld"}, CW'(o_C_vld), CW'(1));
      chk({tag, "_sb"}, CW'(sb.size() != 0), CW'(1));
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         chk({tag, "_C"}, o_C, exp);
      end
   endtask

   task automatic handshake();
      i_C_rdy = 1'b1;
      tick();
      i_C_rdy = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
   endtask

   initial begin
      logic [CW-1:0]  held;
      logic [W*N-1:0] d;
      logic [N-1:0]   v;
      i_rst_n = 1'b0; i_start = 1'b0; i_lane_vld = '0; i_lane_data = '0; i_C_rdy = 1'b0;
      tick(); tick();
      i_rst_n = 1'b1;
      chk("rst_C",    o_C, '0);
      chk("rst_vld",  CW'(o_C_vld), '0);
      chk("rst_rdy",  CW'(o_lane_rdy), '0);
      chk("rst_err",  CW'(o_err), '0);
      chk("rst_busy", CW'(o_busy), '0);

      // Reset mid-COLLECT after 4 beats
      pulse_start();
      chk("col_rdy",  CW'(o_lane_rdy), CW'(1));
      chk("col_busy", CW'(o_busy), CW'(1));
      beat(3'b111, {3{16'h5555}});
      beat(3'b001, {3{16'h5555}});
      do_reset();
      chk("mrst_C",    o_C, '0);
      chk("mrst_vld",  CW'(o_C_vld), '0);
      chk("mrst_rdy",  CW'(o_lane_rdy), '0);
      chk("mrst_busy", CW'(o_busy), '0);
      chk("mrst_err",  CW'(o_err), '0);
      pulse_start();
      sb.push_back({9{16'h3c00}});
      for (int k = 0; k < N; k++) beat(3'b111, {3{16'h3c00}});
      wait_and_score("ones");
      handshake();

      // Skewed drain: lane j beats at cycles j..j+2
      pulse_start();
      sb.push_back(skew_mat());
      for (int t = 0; t < 2*N-1; t++) begin
         v = '0; d = '0;
         for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) begin
               v[j] = 1'b1;
               d[W*j +: W] = W'(16'h1000*(N-1-(t-j)) + j);
            end
         if (t == 2*N-2) chk("skew_pre_vld", CW'(o_C_vld), '0);
         beat(v, d);
      end
      chk("skew_lat", CW'(o_C_vld), CW'(1));
      wait_and_score("skew");
      handshake();
      chk("skew_idle", CW'(o_busy), '0);

      // Simultaneous lanes, bottom row first
      pulse_start();
      sb.push_back(skew_mat());
      for (int k = 0; k < N; k++) beat(3'b111, row_data(N-1-k));
      wait_and_score("simul");
      chk("simul_err", CW'(o_err), '0);

      // Back-pressure with a stray beat and an ignored start
      held = o_C;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) i_start = 1'b1;
         if (i == 5) begin i_start = 1'b0; i_lane_vld = 3'b010; i_lane_data = {3{16'hbeef}}; end
         tick();
         i_lane_vld = '0; i_start = 1'b0;
         chk("bp_vld", CW'(o_C_vld), CW'(1));
         chk("bp_C",   o_C, held);
         chk("bp_rdy", CW'(o_lane_rdy), '0);
      end
      chk("bp_err", CW'(o_err), CW'(1));
      handshake();
      chk("hs_busy", CW'(o_busy), '0);
      chk("hs_vld",  CW'(o_C_vld), '0);
      chk("hs_keep", o_C, held);
      tick();
      chk("no_queue", CW'(o_busy), '0);

      // Beat in IDLE is an error
      do_reset();
      beat(3'b100, '0);
      chk("idle_err", CW'(o_err), CW'(1));

      // Overflow on lane 1, collection still completes
      do_reset();
      pulse_start();
      sb.push_back(skew_mat());
      for (int k = 0; k < N; k++) begin
         d = '0; d[W*1 +: W] = W'(16'h1000*(N-1-k) + 1);
         beat(3'b010, d);
      end
      chk("ovf_pre_err", CW'(o_err), '0);
      for (int k = 0; k < N; k++) begin
         d = row_data(N-1-k);
         v = 3'b101;
         if (k == 0) begin v = 3'b111; d[W*1 +: W] = 16'hdead; end
         beat(v, d);
      end
      chk("ovf_err", CW'(o_err), CW'(1));
      wait_and_score("ovf");
      handshake();

      // Start during COLLECT restarts and flags error
      do_reset();
      pulse_start();
      beat(3'b111, {3{16'h7777}});
      pulse_start();
      chk("rs_err", CW'(o_err), CW'(1));
      chk("rs_C",   o_C, '0);
      sb.push_back(skew_mat());
      for (int k = 0; k < N; k++) beat(3'b111, row_data(N-1-k));
      wait_and_score("restart");
      handshake();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
